kypd_scanner: RTL and testbench
===============================

// Module: kypd_scanner
// PURPOSE
// - Input-side counterpart of the multiplexed 7-seg driver: scans a 4x4 Pmod KYPD matrix by strobing one column low at a time.
// - Reads the four row lines, debounces over whole scans and reports single-key presses as 4-bit hex codes.
// - Codes are delivered through a valid/ack handshake. Sits between the keypad Pmod pins and the value/control logic that feeds the display.
// PARAMETERS
// - SCAN_DIV        100000  clocks each column is driven (1 ms at 100 MHz); minimum 4
// - DEBOUNCE_SCANS  4       consecutive identical full scans required before the debounced state updates; minimum 1
// PORTS
// - clk        in   1  system clock
// - rst        in   1  reset; synchronous, active-high
// - row        in   4  keypad rows, active-low, asynchronous pins (pull-ups enabled in constraints)
// - col        out  4  keypad column drive, active-low, exactly one bit low
// - key_code   out  4  hex value of the pressed key; stable while key_valid=1
// - key_valid  out  1  key event pending; held until acknowledged
// - key_ack    in   1  consumer accepts key_code (sampled on clk)
// - key_down   out  1  debounced state has at least one key pressed
// - overrun    out  1  sticky: an event was dropped while key_valid=1
// BEHAVIOUR
// - Reset values: col=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0; divider, column index, snapshots and stable count all 0; FSM=IDLE.
// - Reset mid-operation discards any pending key. A key still held after reset produces a fresh event once debounced.
// - row passes through a 2-FF synchronizer before use.
// - Column timing:
//   - divider counts 0..SCAN_DIV-1; col = ~(1<<idx).
//   - idx advances 0->1->2->3->0 when divider wraps.
//   - sample strobe fires on the last divider cycle of each column, so row has settled for SCAN_DIV-3 cycles.
// - Snapshot: bit (idx*4+r) = ~row_sync[r] at the strobe; a full scan ends at the idx=3 strobe.
// - Debounce, at each scan end:
//   - snapshot==prev: stable_cnt saturates up toward DEBOUNCE_SCANS.
//   - otherwise: prev<=snapshot, stable_cnt<=0.
//   - The debounced state deb loads prev on the cycle stable_cnt reaches DEBOUNCE_SCANS; it does not reload while the count stays saturated.
// - key_down = |deb, registered.
// - Event FSM, evaluated on each deb update (n = popcount(deb)):
//   - IDLE: n==1 -> HELD and emit event; n>=2 -> MULTI.
//   - HELD: n==0 -> IDLE; n>=2 -> MULTI; same key -> stay (no auto-repeat).
//   - MULTI: n==0 -> IDLE; otherwise stay. Multi-key chords never emit; MULTI -> single key does not emit.
// - Event emission:
//   - key_valid=0: key_code<=KEY_MAP[index of set bit], key_valid<=1 next cycle.
//   - key_valid=1 and no ack: code unchanged, overrun<=1.
//   - key_valid=1 with key_ack the same cycle: new code loaded, key_valid stays 1.
// - Handshake:
//   - key_ack while key_valid=1 -> key_valid=0 and overrun=0 next cycle (unless a simultaneous event occurs).
//   - key_ack while key_valid=0 is ignored.
// - Latency from stable contact: 2 sync cycles + up to (DEBOUNCE_SCANS+2)*4*SCAN_DIV clocks + 1 cycle to key_valid.
// - Key map, rows top..bottom, cols left..right: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
// STRUCTURE
// - Package kypd_pkg holds:
//   - KEY_MAP[16] constant, index = col*4+row;
//   - COL_RESET=4'b1110;
//   - event FSM state encoding (IDLE, HELD, MULTI);
//   - popcount/first-set helper functions.
// - Sub-module kypd_col_scan: divider + column index + col drive + sample strobe/scan_end outputs.
// - Top level holds the synchronizer, snapshot/debounce, FSM and handshake.
// TESTING (sim with SCAN_DIV=4, DEBOUNCE_SCANS=2; keypad model pulls row[r] low when col low on a pressed key)
// - Reset: release rst -> col=1110, key_valid=0, key_down=0; col=1101 after 4 clks; full cycle 1110,1101,1011,0111 every 16 clks.
// - Press '5' (col1,row1), held, never acked -> key_valid=1, key_code=5 within 2+4*16+1 clks. Ack -> key_valid=0 next clk; no repeat while held.
// - Bounce '9': row pulses low for 6 clks, repeated at intervals shorter than 2 scans -> key_valid stays 0, key_down stays 0.
// - Chord '1'+'2' held -> key_down=1, key_valid=0. Release '2' only -> still no event. Release all, then press '2' -> key_code=2.
// - Overrun: press/release '0' without ack, then press 'D' -> key_code=0, overrun=1. Ack -> key_valid=0, overrun=0. Ack in the same cycle as a new event -> key_valid stays 1 with the new code.
// - Reset mid-press: assert rst while 'A' pending -> all outputs at reset values. Keep 'A' held -> fresh key_valid, key_code=A after debounce.

Source files
------------

// File: rtl/kypd_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
// - KEY_MAP: hex code of each key, indexed by col*4+row (col 0 = left, row 0 = top).
// - COL_RESET: column drive after reset (column 0 strobed).
// - evt_state_e: key event FSM states.
// - popcount16 / first_set: helpers over the 16-bit key snapshot.
package kypd_pkg;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Face layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D, stored column-major.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StMulti
    } evt_state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    // Index of the lowest set bit; 0 when v is empty.
    function automatic logic [3:0] first_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/kypd_col_scan.sv
// Column strobe generator for the keypad matrix.
// - clk, rst   : system clock, synchronous active-high reset
// - col        : active-low column drive, exactly one bit low
// - idx        : index of the column currently driven
// - strobe     : last divider cycle of the current column (row sample point)
// - scan_end   : strobe of column 3, i.e. a full scan is complete
module kypd_col_scan
    import kypd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    output logic [1:0] idx,
    output logic       strobe,
    output logic       scan_end
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      col_q, col_d;

    always_comb begin
        strobe   = (div_q == DivLast);
        scan_end = strobe && (idx_q == 2'd3);
        div_d    = strobe ? '0 : div_q + 1'b1;
        idx_d    = strobe ? idx_q + 2'd1 : idx_q;
        col_d    = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
            col_q <= COL_RESET;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            col_q <= col_d;
        end
    end

    assign col = col_q;
    assign idx = idx_q;

endmodule

// File: rtl/kypd_scanner.sv
// 4x4 keypad scanner: strobes columns, debounces whole scans and reports single-key
// presses as hex codes over a valid/ack handshake.
// - clk, rst   : system clock, synchronous active-high reset
// - row        : keypad rows, active-low, asynchronous
// - col        : keypad column drive, active-low, one bit low
// - key_code   : hex value of the pending key, stable while key_valid=1
// - key_valid  : key event pending until key_ack
// - key_ack    : consumer accepts key_code
// - key_down   : debounced state has at least one key pressed
// - overrun    : sticky, an event was dropped while key_valid=1; cleared by key_ack
module kypd_scanner
    import kypd_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0] CntPre = CntW'(DEBOUNCE_SCANS - 1);

    logic [1:0] idx;
    logic       strobe, scan_end;

    kypd_col_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_col_scan (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .idx      (idx),
        .strobe   (strobe),
        .scan_end (scan_end)
    );

    logic [3:0]      row_meta_q, row_sync_q;
    logic [15:0]     snap_q, snap_d, snap_full;
    logic [15:0]     prev_q, prev_d;
    logic [15:0]     deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            deb_load, emit;
    logic [4:0]      n_keys;
    evt_state_e      state_q, state_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            over_q, over_d;
    logic            down_q, down_d;

    always_comb begin
        // Snapshot including the column being sampled right now, so scan_end sees all 16 keys.
        snap_full                     = snap_q;
        snap_full[{idx, 2'b00} +: 4]  = ~row_sync_q;
        snap_d                        = strobe ? snap_full : snap_q;

        prev_d   = prev_q;
        cnt_d    = cnt_q;
        deb_load = 1'b0;
        if (scan_end) begin
            if (snap_full == prev_q) begin
                if (cnt_q != CntMax) begin
                    cnt_d    = cnt_q + 1'b1;
                    deb_load = (cnt_q == CntPre);
                end
            end else begin
                prev_d = snap_full;
                cnt_d  = '0;
            end
        end
        deb_d  = deb_load ? prev_q : deb_q;
        down_d = |deb_d;

        // Event FSM runs only when the debounced state is (re)loaded.
        n_keys  = popcount16(prev_q);
        state_d = state_q;
        emit    = 1'b0;
        if (deb_load) begin
            unique case (state_q)
                StIdle: begin
                    if (n_keys == 5'd1) begin
                        state_d = StHeld;
                        emit    = 1'b1;
                    end else if (n_keys >= 5'd2) begin
                        state_d = StMulti;
                    end
                end
                StHeld: begin
                    if (n_keys == 5'd0) begin
                        state_d = StIdle;
                    end else if (n_keys >= 5'd2) begin
                        state_d = StMulti;
                    end else if (prev_q != deb_q) begin
                        // A different single key replaced the held one: a new press.
                        emit = 1'b1;
                    end
                end
                StMulti: begin
                    if (n_keys == 5'd0) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        code_d  = code_q;
        valid_d = valid_q;
        over_d  = over_q;
        if (emit) begin
            if (!valid_q || key_ack) begin
                code_d  = KEY_MAP[first_set(prev_q)];
                valid_d = 1'b1;
                over_d  = 1'b0;
            end else begin
                over_d = 1'b1;
            end
        end else if (valid_q && key_ack) begin
            valid_d = 1'b0;
            over_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            snap_q     <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            deb_q      <= '0;
            down_q     <= 1'b0;
            state_q    <= StIdle;
            code_q     <= '0;
            valid_q    <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            snap_q     <= snap_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            down_q     <= down_d;
            state_q    <= state_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            over_q     <= over_d;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;
    assign overrun   = over_q;

endmodule

// File: tb/tb_kypd_scanner.sv
// Self-checking bench for kypd_scanner with a behavioural keypad and an event-level model.
module tb_kypd_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int          SETTLE   = 90;

    // Key faces as printed, [row][col].
    localparam logic [3:0] FACE [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack = 1'b0;
    logic        key_down;
    logic        overrun;
    logic [15:0] pressed = '0;   // bit c*4+r = key at (row r, col c) closed

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Keypad: a closed key shorts its row to its column; rows pulled up otherwise.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col[c] && pressed[c*4+r]) row[r] = 1'b0;
            end
        end
    end

    kypd_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    function automatic int kbit(input int r, input int c);
        return c * 4 + r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst = 1'b1;
        tick(3);
        n_tests++;
        if (col !== 4'b1110) begin
            n_fail++; $display("FAIL reset_col: got %b expected 1110", col);
        end
        n_tests++;
        if ({key_valid, key_down, overrun, key_code} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%b o=%b code=%h expected all 0",
                     key_valid, key_down, overrun, key_code);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick(SCAN_DIV);
            exp_col = ~(4'b0001 << (k % 4));
            n_tests++;
            if (col !== exp_col) begin
                n_fail++; $display("FAIL col_seq_%0d: got %b expected %b", k, col, exp_col);
            end
        end
    endtask

    task automatic test_press_5();
        int waited;
        pressed = '0;
        pressed[kbit(1, 1)] = 1'b1;
        waited = 0;
        while (!key_valid && waited < 2 + 4 * 16 + 1) begin
            tick(1);
            waited++;
        end
        n_tests++;
        if (key_valid !== 1'b1) begin
            n_fail++; $display("FAIL press5_valid: got %b expected 1 within 67 clks", key_valid);
        end
        tick(20);
        n_tests++;
        if (key_valid !== 1'b1 || key_code !== FACE[1][1]) begin
            n_fail++;
            $display("FAIL press5_code: got v=%b code=%h expected v=1 code=%h",
                     key_valid, key_code, FACE[1][1]);
        end
        ack_pulse();
        n_tests++;
        if (key_valid !== 1'b0) begin
            n_fail++; $display("FAIL press5_ack: got %b expected 0", key_valid);
        end
        tick(100);
        n_tests++;
        if (key_valid !== 1'b0 || key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL press5_norepeat: got v=%b d=%b expected v=0 d=1", key_valid, key_down);
        end
        pressed = '0;
        tick(100);
        n_tests++;
        if (key_down !== 1'b0) begin
            n_fail++; $display("FAIL press5_release: got %b expected 0", key_down);
        end
    endtask

    task automatic test_bounce_9();
        logic seen_valid, seen_down;
        seen_valid = 1'b0;
        seen_down  = 1'b0;
        // Contact closes for 6 clks every 20 clks: never three consecutive equal scans.
        for (int p = 0; p < 10; p++) begin
            for (int t = 0; t < 20; t++) begin
                pressed[kbit(2, 2)] = (t < 6);
                tick(1);
                seen_valid |= key_valid;
                seen_down  |= key_down;
            end
        end
        pressed = '0;
        n_tests++;
        if (seen_valid !== 1'b0) begin
            n_fail++; $display("FAIL bounce_valid: got %b expected 0", seen_valid);
        end
        n_tests++;
        if (seen_down !== 1'b0) begin
            n_fail++; $display("FAIL bounce_down: got %b expected 0", seen_down);
        end
        tick(100);
    endtask

    task automatic test_chord();
        pressed = '0;
        pressed[kbit(0, 0)] = 1'b1;
        pressed[kbit(0, 1)] = 1'b1;
        tick(100);
        n_tests++;
        if (key_down !== 1'b1 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL chord_held: got d=%b v=%b expected d=1 v=0", key_down, key_valid);
        end
        pressed[kbit(0, 1)] = 1'b0;
        tick(100);
        n_tests++;
        if (key_down !== 1'b1 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL chord_partial: got d=%b v=%b expected d=1 v=0", key_down, key_valid);
        end
        pressed = '0;
        tick(100);
        pressed[kbit(0, 1)] = 1'b1;
        tick(100);
        n_tests++;
        if (key_valid !== 1'b1 || key_code !== FACE[0][1]) begin
            n_fail++;
            $display("FAIL chord_then_2: got v=%b code=%h expected v=1 code=%h",
                     key_valid, key_code, FACE[0][1]);
        end
        ack_pulse();
        pressed = '0;
        tick(100);
    endtask

    task automatic test_overrun();
        logic [3:0] last_col;
        int         guard;
        pressed[kbit(3, 0)] = 1'b1;
        tick(100);
        pressed = '0;
        tick(100);
        pressed[kbit(3, 3)] = 1'b1;
        tick(100);
        n_tests++;
        if (key_valid !== 1'b1 || key_code !== FACE[3][0] || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got v=%b code=%h o=%b expected v=1 code=%h o=1",
                     key_valid, key_code, overrun, FACE[3][0]);
        end
        ack_pulse();
        n_tests++;
        if (key_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_ack: got v=%b o=%b expected v=0 o=0", key_valid, overrun);
        end
        pressed = '0;
        tick(100);
        // Queue '0' again, then ack exactly on the cycle the 'D' event fires.
        pressed[kbit(3, 0)] = 1'b1;
        tick(100);
        pressed = '0;
        tick(100);
        n_tests++;
        if (key_valid !== 1'b1 || key_code !== FACE[3][0] || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_requeue: got v=%b code=%h o=%b expected v=1 code=%h o=0",
                     key_valid, key_code, overrun, FACE[3][0]);
        end
        last_col = col;
        guard    = 0;
        tick(1);
        while (!(last_col == 4'b0111 && col == 4'b1110) && guard < 40) begin
            last_col = col;
            tick(1);
            guard++;
        end
        n_tests++;
        if (guard >= 40) begin
            n_fail++; $display("FAIL scan_align: got no scan start expected one within 40 clks");
        end
        // Scan start: press lands, event fires on the third scan end (cycle 47).
        pressed[kbit(3, 3)] = 1'b1;
        tick(47);
        ack_pulse();
        n_tests++;
        if (key_valid !== 1'b1 || key_code !== FACE[3][3] || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_with_event: got v=%b code=%h o=%b expected v=1 code=%h o=0",
                     key_valid, key_code, overrun, FACE[3][3]);
        end
        ack_pulse();
        pressed = '0;
        tick(100);
    endtask

    task automatic test_reset_mid_press();
        pressed[kbit(0, 3)] = 1'b1;
        tick(100);
        n_tests++;
        if (key_valid !== 1'b1 || key_code !== FACE[0][3]) begin
            n_fail++;
            $display("FAIL rstmid_pending: got v=%b code=%h expected v=1 code=%h",
                     key_valid, key_code, FACE[0][3]);
        end
        rst = 1'b1;
        tick(2);
        n_tests++;
        if ({col, key_code, key_valid, key_down, overrun} !== {4'b1110, 4'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL rstmid_reset: got col=%b code=%h v=%b d=%b o=%b expected 1110 0 0 0 0",
                     col, key_code, key_valid, key_down, overrun);
        end
        rst = 1'b0;
        tick(100);
        n_tests++;
        if (key_valid !== 1'b1 || key_code !== FACE[0][3]) begin
            n_fail++;
            $display("FAIL rstmid_fresh: got v=%b code=%h expected v=1 code=%h",
                     key_valid, key_code, FACE[0][3]);
        end
        ack_pulse();
        pressed = '0;
        tick(100);
    endtask

    // Event-level model: each phase holds one key pattern long enough to debounce.
    task automatic test_random();
        int          m_state;   // 0 idle, 1 one key held, 2 chord seen
        logic [15:0] m_deb, mask;
        logic        m_valid, m_over;
        logic [3:0]  m_code;
        int          kind, a, b, n;
        pressed = '0;
        tick(100);
        ack_pulse();
        m_state = 0; m_deb = '0; m_valid = 1'b0; m_over = 1'b0; m_code = '0;
        for (int ph = 0; ph < 24; ph++) begin
            kind = $urandom_range(0, 3);
            mask = '0;
            a = $urandom_range(0, 15);
            if (kind == 1 || kind == 2) mask[a] = 1'b1;
            if (kind == 3) begin
                b = (a + $urandom_range(1, 15)) % 16;
                mask[a] = 1'b1;
                mask[b] = 1'b1;
            end
            pressed = mask;
            tick(SETTLE);
            if (mask != m_deb) begin
                n = $countones(mask);
                if (n == 0) begin
                    m_state = 0;
                end else if (n >= 2) begin
                    m_state = 2;
                end else if (m_state == 0 || m_state == 1) begin
                    m_state = 1;
                    if (!m_valid) begin
                        m_valid = 1'b1;
                        m_code  = FACE[a % 4][a / 4];
                    end else begin
                        m_over = 1'b1;
                    end
                end
                m_deb = mask;
            end
            n_tests++;
            if (key_valid !== m_valid || overrun !== m_over || key_down !== (mask != 0)) begin
                n_fail++;
                $display("FAIL rand_%0d_flags: got v=%b o=%b d=%b expected v=%b o=%b d=%b",
                         ph, key_valid, overrun, key_down, m_valid, m_over, mask != 0);
            end
            if (m_valid) begin
                n_tests++;
                if (key_code !== m_code) begin
                    n_fail++;
                    $display("FAIL rand_%0d_code: got %h expected %h", ph, key_code, m_code);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                ack_pulse();
                m_valid = 1'b0;
                m_over  = 1'b0;
                n_tests++;
                if (key_valid !== 1'b0 || overrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_%0d_ack: got v=%b o=%b expected 0 0",
                             ph, key_valid, overrun);
                end
            end
        end
        pressed = '0;
        tick(100);
    endtask

    initial begin
        test_reset();
        test_press_5();
        test_bounce_9();
        test_chord();
        test_overrun();
        test_reset_mid_press();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1 ms");
        $fatal(1);
    end

endmodule
